// File: rtl/fir_response_checker.sv
// Response-side checker for the 3-tap FIR filter: rebuilds the golden output from the
// observed input stream, latency-aligns it and scores fir_out against it every cycle.
module fir_response_checker #(
  parameter int width = 8,
  parameter int LAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [width-1:0]     fir_in_i,
  input  logic [width-1:0]     w_1_i,
  input  logic [width-1:0]     w_2_i,
  input  logic [width-1:0]     w_3_i,
  input  logic [2*width-1:0]   fir_out_i,
  output logic [2*width-1:0]   expected_o,
  output logic                 mismatch_o,
  output logic [CNT_W-1:0]     chk_cnt_o,
  output logic [CNT_W-1:0]     err_cnt_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o
);

  localparam int OW       = 2 * width;
  localparam int FILL_LEN = 2 + LAT;
  localparam int FW       = $clog2(FILL_LEN + 1);
  localparam logic [FW-1:0]    FILL_LAST = FW'(FILL_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_e;

  state_e             state_q, state_d;
  logic [FW-1:0]      fillCnt_q, fillCnt_d;
  logic [width-1:0]   x1_q, x2_q;
  logic [OW-1:0]      golden;
  logic [OW-1:0]      delay_q [LAT];
  logic [CNT_W-1:0]   chkCnt_q, chkCnt_d;
  logic [CNT_W-1:0]   errCnt_q, errCnt_d;
  logic               mismatch_q, mismatch_d;
  logic               busy_q, done_q, pass_q;
  logic               running;
  logic               differ;

  // Products are full width; the three-way sum wraps modulo 2^(2*width) like the filter's.
  assign golden = OW'(w_1_i) * OW'(fir_in_i)
                + OW'(w_2_i) * OW'(x1_q)
                + OW'(w_3_i) * OW'(x2_q);

  assign running = (state_q != IDLE);
  assign differ  = (fir_out_i != delay_q[LAT-1]);

  always_comb begin
    state_d    = state_q;
    fillCnt_d  = fillCnt_q;
    chkCnt_d   = chkCnt_q;
    errCnt_d   = errCnt_q;
    mismatch_d = 1'b0;
    if (start_i) begin
      state_d   = FILL;
      fillCnt_d = '0;
      chkCnt_d  = '0;
      errCnt_d  = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (stop_i) begin
            state_d = DONE;
          end else if (fillCnt_q == FILL_LAST) begin
            state_d = CHECK;
          end else begin
            fillCnt_d = fillCnt_q + 1'b1;
          end
        end
        CHECK: begin
          if (chkCnt_q != CNT_MAX) chkCnt_d = chkCnt_q + 1'b1;
          if (differ) begin
            mismatch_d = 1'b1;
            if (errCnt_q != CNT_MAX) errCnt_d = errCnt_q + 1'b1;
          end
          if (stop_i) state_d = DONE;
        end
        default: ;
      endcase
    end
  end

  // Status flags are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      fillCnt_q  <= '0;
      x1_q       <= '0;
      x2_q       <= '0;
      for (int i = 0; i < LAT; i++) delay_q[i] <= '0;
      chkCnt_q   <= '0;
      errCnt_q   <= '0;
      mismatch_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fillCnt_q  <= fillCnt_d;
      chkCnt_q   <= chkCnt_d;
      errCnt_q   <= errCnt_d;
      mismatch_q <= mismatch_d;
      busy_q     <= (state_d == FILL) || (state_d == CHECK);
      done_q     <= (state_d == DONE);
      pass_q     <= (state_d == DONE) && (errCnt_d == '0) && (chkCnt_d != '0);
      if (start_i) begin
        x1_q <= '0;
        x2_q <= '0;
        for (int i = 0; i < LAT; i++) delay_q[i] <= '0;
      end else if (running) begin
        x1_q       <= fir_in_i;
        x2_q       <= x1_q;
        delay_q[0] <= golden;
        for (int i = 1; i < LAT; i++) delay_q[i] <= delay_q[i-1];
      end
    end
  end

  assign expected_o = delay_q[LAT-1];
  assign mismatch_o = mismatch_q;
  assign chk_cnt_o  = chkCnt_q;
  assign err_cnt_o  = errCnt_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pass_o     = pass_q;

endmodule

// File: tb/tb_fir_response_checker.sv
// Directed bench for fir_response_checker: a behavioural 3-tap filter drives fir_out, and a
// second checker with 4-bit counters watches a stuck-at-zero output to exercise saturation.
module tb_fir_response_checker;

  logic        clk = 1'b0;
  logic        rst, start, stop, corrupt;
  logic [7:0]  firIn, w1, w2, w3;
  logic [7:0]  fx1, fx2;
  logic [15:0] firReg, firOut, firZero;

  logic [15:0] expected;
  logic        mismatch, busy, done, pass;
  logic [15:0] chkCnt, errCnt;

  logic [15:0] satExpected;
  logic        satMismatch, satBusy, satDone, satPass;
  logic [3:0]  satChk, satErr;

  int checkCount = 0;
  int passCount  = 0;

  localparam logic [15:0] YA = 16'h5AA5;
  localparam logic [15:0] YB = 16'hFE01;
  localparam logic [15:0] YC = 16'hE11E;
  localparam logic [15:0] YW = 16'hDF1F;

  typedef struct packed {
    logic        start;
    logic        stop;
    logic [7:0]  fin;
    logic        corrupt;
    logic [15:0] expv;
    logic        mis;
    logic [15:0] chk;
    logic [15:0] err;
    logic        busy;
    logic        done;
    logic        pass;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  // Reference filter with one cycle of latency; bit 0 can be flipped to inject faults.
  always_ff @(posedge clk) begin
    firReg <= 16'(w1) * 16'(firIn) + 16'(w2) * 16'(fx1) + 16'(w3) * 16'(fx2);
    fx1    <= firIn;
    fx2    <= fx1;
  end

  assign firOut  = firReg ^ {15'd0, corrupt};
  assign firZero = 16'd0;

  fir_response_checker #(.width(8), .LAT(1), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
    .fir_in_i(firIn), .w_1_i(w1), .w_2_i(w2), .w_3_i(w3), .fir_out_i(firOut),
    .expected_o(expected), .mismatch_o(mismatch), .chk_cnt_o(chkCnt), .err_cnt_o(errCnt),
    .busy_o(busy), .done_o(done), .pass_o(pass)
  );

  fir_response_checker #(.width(8), .LAT(1), .CNT_W(4)) satDut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
    .fir_in_i(firIn), .w_1_i(w1), .w_2_i(w2), .w_3_i(w3), .fir_out_i(firZero),
    .expected_o(satExpected), .mismatch_o(satMismatch), .chk_cnt_o(satChk), .err_cnt_o(satErr),
    .busy_o(satBusy), .done_o(satDone), .pass_o(satPass)
  );

  function automatic vec_t mk(input logic s, input logic p, input logic [7:0] f, input logic c,
                              input logic [15:0] e, input logic m, input logic [15:0] ck,
                              input logic [15:0] er, input logic b, input logic d, input logic ps);
    vec_t v;
    v.start = s; v.stop = p; v.fin = f; v.corrupt = c; v.expv = e; v.mis = m;
    v.chk = ck; v.err = er; v.busy = b; v.done = d; v.pass = ps;
    return v;
  endfunction

  task automatic applyStimulus(input logic r, input logic s, input logic p,
                               input logic [7:0] f, input logic c);
    rst = r; start = s; stop = p; firIn = f; corrupt = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    checkCount++;
    if (act !== want)
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    else
      passCount++;
  endtask

  task automatic checkAll(input string tag, input logic [15:0] e, input logic m,
                          input logic [15:0] ck, input logic [15:0] er,
                          input logic b, input logic d, input logic ps);
    checkOutput({tag, ".expected"}, expected, e);
    checkOutput({tag, ".mismatch"}, mismatch, m);
    checkOutput({tag, ".chk_cnt"},  chkCnt,   ck);
    checkOutput({tag, ".err_cnt"},  errCnt,   er);
    checkOutput({tag, ".busy"},     busy,     b);
    checkOutput({tag, ".done"},     done,     d);
    checkOutput({tag, ".pass"},     pass,     ps);
  endtask

  initial begin
    w1 = 8'h5B; w2 = 8'hFF; w3 = 8'h87;

    // Alternating run with the correct filter, ended by stop: should pass.
    vecs.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'hFF, 0, YA, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, YB, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'hFF, 0, YC, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, YB, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'hFF, 0, YC, 0, 2, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, YB, 0, 3, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'hFF, 0, YC, 0, 4, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, YB, 0, 5, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'hFF, 0, YC, 0, 6, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, YB, 0, 6, 0, 0, 1, 1));
    // Restart from DONE, flip bit 0 on three CHECK cycles.
    vecs.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'hFF, 0, YA, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, YB, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'hFF, 0, YC, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, YB, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'hFF, 1, YC, 1, 2, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, YB, 0, 3, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'hFF, 1, YC, 1, 4, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, YB, 1, 5, 3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'hFF, 0, YC, 0, 6, 3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, YB, 0, 7, 3, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'hFF, 0, YC, 0, 8, 3, 0, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, YB, 0, 8, 3, 0, 1, 0));
    // Corruption confined to the fill window must not be scored.
    vecs.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'hFF, 1, YA, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, YB, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'hFF, 1, YC, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, YB, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'hFF, 0, YC, 0, 2, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, YB, 0, 3, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'hFF, 0, YC, 0, 4, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, YB, 0, 4, 0, 0, 1, 1));

    applyStimulus(1, 0, 0, 8'h00, 0);
    applyStimulus(1, 0, 0, 8'h00, 0);
    checkAll("reset", 16'h0000, 0, 0, 0, 0, 0, 0);
    checkOutput("reset.sat_chk", satChk, 0);
    checkOutput("reset.sat_err", satErr, 0);
    applyStimulus(0, 0, 0, 8'hFF, 0);
    checkAll("idle", 16'h0000, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(0, vecs[i].start, vecs[i].stop, vecs[i].fin, vecs[i].corrupt);
      checkAll($sformatf("row%0d", i), vecs[i].expv, vecs[i].mis, vecs[i].chk, vecs[i].err,
               vecs[i].busy, vecs[i].done, vecs[i].pass);
    end

    // Held 0xFF input wraps the sum; the stuck-at-zero checker saturates at 0xF.
    applyStimulus(0, 1, 0, 8'hFF, 0);
    applyStimulus(0, 0, 0, 8'hFF, 0);
    applyStimulus(0, 0, 0, 8'hFF, 0);
    applyStimulus(0, 0, 0, 8'hFF, 0);
    checkOutput("wrap.fill_expected", expected, YW);
    checkOutput("wrap.fill_chk", chkCnt, 0);
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(0, 0, 0, 8'hFF, 0);
      checkOutput($sformatf("wrap.expected%0d", i), expected, YW);
      checkOutput($sformatf("wrap.mismatch%0d", i), mismatch, 0);
      checkOutput($sformatf("wrap.chk%0d", i), chkCnt, i);
      checkOutput($sformatf("sat.expected%0d", i), satExpected, YW);
      checkOutput($sformatf("sat.mismatch%0d", i), satMismatch, 1);
      checkOutput($sformatf("sat.chk%0d", i), satChk, (i < 15) ? i : 15);
      checkOutput($sformatf("sat.err%0d", i), satErr, (i < 15) ? i : 15);
    end
    checkOutput("wrap.err", errCnt, 0);
    applyStimulus(0, 0, 1, 8'hFF, 0);
    checkAll("wrap.stop", YW, 0, 21, 0, 0, 1, 1);
    checkOutput("sat.stop_chk", satChk, 4'hF);
    checkOutput("sat.stop_err", satErr, 4'hF);
    checkOutput("sat.stop_busy", satBusy, 0);
    checkOutput("sat.stop_done", satDone, 1);
    checkOutput("sat.stop_pass", satPass, 0);
    applyStimulus(0, 0, 0, 8'hFF, 0);
    checkOutput("sat.hold_chk", satChk, 4'hF);
    checkOutput("sat.hold_err", satErr, 4'hF);
    checkOutput("wrap.hold_chk", chkCnt, 21);

    // Reset in the middle of CHECK clears everything and parks in IDLE.
    applyStimulus(0, 1, 0, 8'hFF, 0);
    repeat (3) applyStimulus(0, 0, 0, 8'hFF, 0);
    applyStimulus(0, 0, 0, 8'hFF, 1);
    checkAll("prerst", YW, 1, 1, 1, 1, 0, 0);
    applyStimulus(1, 0, 0, 8'hFF, 0);
    checkAll("rstmid", 16'h0000, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 8'hFF, 0);
    checkAll("rstidle", 16'h0000, 0, 0, 0, 0, 0, 0);

    // start together with stop in CHECK restarts the fill window.
    applyStimulus(0, 1, 0, 8'hFF, 0);
    repeat (3) applyStimulus(0, 0, 0, 8'hFF, 0);
    applyStimulus(0, 0, 0, 8'hFF, 0);
    applyStimulus(0, 0, 0, 8'hFF, 1);
    checkOutput("both.pre_chk", chkCnt, 2);
    checkOutput("both.pre_err", errCnt, 1);
    applyStimulus(0, 1, 1, 8'hFF, 0);
    checkOutput("both.busy", busy, 1);
    checkOutput("both.done", done, 0);
    checkOutput("both.chk", chkCnt, 0);
    checkOutput("both.err", errCnt, 0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 0, 0, 8'hFF, 0);
      checkOutput($sformatf("both.fill_chk%0d", i), chkCnt, 0);
      checkOutput($sformatf("both.fill_busy%0d", i), busy, 1);
    end
    applyStimulus(0, 0, 0, 8'hFF, 0);
    checkOutput("both.first_chk", chkCnt, 1);

    // stop while still filling ends the run with no comparisons and no pass.
    applyStimulus(0, 1, 0, 8'hFF, 0);
    applyStimulus(0, 0, 1, 8'hFF, 0);
    checkOutput("fillstop.done", done, 1);
    checkOutput("fillstop.busy", busy, 0);
    checkOutput("fillstop.pass", pass, 0);
    checkOutput("fillstop.chk", chkCnt, 0);
    applyStimulus(0, 0, 0, 8'hFF, 0);
    checkOutput("fillstop.hold_done", done, 1);
    checkOutput("fillstop.hold_pass", pass, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fir_response_checker.md
# fir_response_checker

Synthesizable response-side checker for the 3-tap `fir_filter`. It sits beside the filter and observes the same `fir_in`/`w_1..w_3` stream the stimulus side drives. It computes the golden output through its own tap history and latency-matched delay line, and compares it against `fir_out` every cycle. It reports per-cycle mismatch pulses, saturating check/error counters and a final pass/fail verdict.

## Interface
- `width`, 8, sample and weight width; output width is 2*width
- `LAT`, 1, cycles from `fir_in` sampling edge to the edge at which the matching `fir_out` is sampled (1..8)
- `CNT_W`, 16, width of check and error counters

- `clk`  in  1  rising-edge clock, same as `fir_filter`
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  begin a check run (clears counters, enters FILL)
- `stop`  in  1  end a check run (enters DONE)
- `fir_in`  in  width  filter input sample, unsigned
- `w_1`, `w_2`, `w_3`  in  width each  tap weights, unsigned
- `fir_out`  in  2*width  filter output under check
- `expected`  out  2*width  golden value compared this cycle
- `mismatch`  out  1  one-cycle pulse, `fir_out` != `expected` in CHECK
- `chk_cnt`  out  CNT_W  comparisons performed, saturating
- `err_cnt`  out  CNT_W  mismatches, saturating
- `busy`  out  1  state is FILL or CHECK
- `done`  out  1  state is DONE
- `pass`  out  1  valid while `done`=1; 1 iff `err_cnt`==0 and `chk_cnt`!=0

## Operation
- Golden model: y[n] = w_1·x[n] + w_2·x[n-1] + w_3·x[n-2]. All operands are unsigned. Products are full 2*width bits, and the sum is truncated modulo 2^(2*width).
- Weights are taken from the same edge as x[n]. Mid-run weight changes are therefore checked exactly as the filter sees them.
- Tap history x1/x2 shifts on every clock in all states except IDLE. It is cleared to 0 on `rst` and on `start`.
- The golden y enters a LAT-deep delay line. `expected` is the delay-line output.
- FSM states:
  - IDLE: reset state, all outputs 0. `start` goes to FILL.
  - FILL: a fill counter counts 2+LAT clocks, then moves to CHECK. No comparisons are made. `stop` goes to DONE.
  - CHECK: every clock, compare `fir_out` against `expected`, increment `chk_cnt`, and on inequality pulse `mismatch` and increment `err_cnt`. `stop` goes to DONE.
  - DONE: counters and `pass` hold. `start` goes to FILL.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Simultaneous `start` and `stop` in any state: `start` wins. The block restarts in FILL with counters cleared, including from CHECK.
- `rst` mid-run: the next state is IDLE, and all counters, history, delay line and outputs are 0.

## Timing
- `start` sampled at edge k: the state is FILL from k+1, and x[0] is the `fir_in` sampled at edge k+1.
- The first comparison happens at edge k+3+LAT. `mismatch` and the counter updates are registered and visible after that edge.
- `stop` sampled in CHECK: that edge's comparison is still counted. DONE is visible the following cycle.
- `expected` is registered and always reflects the value used for the current-cycle comparison.
- Reset values: `expected`=0, `mismatch`=0, `chk_cnt`=0, `err_cnt`=0, `busy`=0, `done`=0, `pass`=0.

## Test plan
- Alternating stimulus, w_1=0x5B, w_2=0xFF, w_3=0x87, `fir_in` toggling 0xFF/0x00 each cycle, correct filter connected, LAT=1 -> `expected` alternates 0xE11E and 0xFE01, `mismatch` never asserts, `stop` gives `pass`=1.
- Wrap-around: same weights, `fir_in` held at 0xFF -> `expected`=0xDF1F (122655 mod 65536), no mismatch.
- Fault injection: XOR bit 0 of `fir_out` for exactly 3 CHECK cycles -> 3 `mismatch` pulses aligned to those cycles, `err_cnt`=3, `pass`=0 in DONE.
- FILL masking: corrupt `fir_out` during the first 2+LAT cycles after `start` only -> `err_cnt`=0, and `chk_cnt` equals the CHECK cycles only.
- Saturation: CNT_W=4, filter output forced to 0 with nonzero stimulus for 20 CHECK cycles -> `err_cnt`=`chk_cnt`=0xF, both hold.
- Control corners: `rst` asserted mid-CHECK -> all outputs 0 next cycle, state IDLE. `start`+`stop` together in CHECK -> FILL with counters 0. `stop` during FILL -> DONE with `pass`=0.
